baud_tick_generator: RTL and testbench

Programmable fractional baud-rate tick generator for the UART. It replaces the fixed mod-M counter with a run-time loadable divisor made of an integer part and a fractional part. It produces an oversample tick for the rx/tx samplers and a derived 1x bit tick. It sits between the clock domain and `uart_rx`/`uart_tx`, and the divisor is driven from the interface/config block.

---
 rtl/baud_tick_generator_if.sv | 31 +++
 rtl/baud_tick_generator.sv | 70 +++++++
 tb/tb_baud_tick_generator.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/baud_tick_generator_if.sv
// Control/status bundle between the UART config block and the baud tick generator.
// The master drives the divisor and strobes. The slave returns the two tick pulses.
interface baud_tick_generator_if #(
    parameter int N = 16,
    parameter int F = 4
) ();
    logic         i_enable;
    logic         i_load;
    logic [N-1:0] i_div_int;
    logic [F-1:0] i_div_frac;
    logic         o_tick;
    logic         o_bit_tick;

    modport master (
        output i_enable,
        output i_load,
        output i_div_int,
        output i_div_frac,
        input  o_tick,
        input  o_bit_tick
    );

    modport slave (
        input  i_enable,
        input  i_load,
        input  i_div_int,
        input  i_div_frac,
        output o_tick,
        output o_bit_tick
    );
endinterface

// File: rtl/baud_tick_generator.sv
// Fractional baud-rate tick generator with a run-time divisor of DIV_INT + DIV_FRAC/2^F.
// It produces an oversample tick and a 1x bit tick on every OVS-th oversample tick.
module baud_tick_generator #(
    parameter int N        = 16,
    parameter int F        = 4,
    parameter int OVS      = 16,
    parameter int DEF_INT  = 651,
    parameter int DEF_FRAC = 0
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    baud_tick_generator_if.slave    bus
);
    localparam int            OW        = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [OW-1:0] OCNT_LAST = OW'(OVS - 1);

    logic [N-1:0]  div_int_q;
    logic [F-1:0]  div_frac_q;
    logic [N-1:0]  cnt;
    logic [F-1:0]  facc;
    logic          ext_q;
    logic [OW-1:0] ocnt;

    logic [N-1:0]  eff;
    logic [N:0]    term_lim;
    logic          term;
    logic [F:0]    frac_sum;
    logic          ocnt_last;
    logic          tick;

    // The limit is compared one bit wider so that eff = 2^N-1 plus the extension cycle cannot wrap.
    always_comb begin
        eff       = (div_int_q == '0) ? N'(1) : div_int_q;
        term_lim  = {1'b0, eff} - (N+1)'(1) + {{N{1'b0}}, ext_q};
        term      = ({1'b0, cnt} == term_lim);
        frac_sum  = {1'b0, facc} + {1'b0, div_frac_q};
        ocnt_last = (ocnt == OCNT_LAST);
        tick      = bus.i_enable & term & ~bus.i_load;
    end

    assign bus.o_tick     = tick;
    assign bus.o_bit_tick = tick & ocnt_last;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_int_q  <= N'(DEF_INT);
            div_frac_q <= F'(DEF_FRAC);
            cnt        <= '0;
            facc       <= '0;
            ext_q      <= 1'b0;
            ocnt       <= '0;
        end else if (bus.i_load) begin
            div_int_q  <= bus.i_div_int;
            div_frac_q <= bus.i_div_frac;
            cnt        <= '0;
            facc       <= '0;
            ext_q      <= 1'b0;
            ocnt       <= '0;
        end else if (bus.i_enable) begin
            if (term) begin
                cnt   <= '0;
                facc  <= frac_sum[F-1:0];
                ext_q <= frac_sum[F];
                ocnt  <= ocnt_last ? '0 : ocnt + OW'(1);
            end else begin
                cnt   <= cnt + N'(1);
            end
        end
    end
endmodule

// File: tb/tb_baud_tick_generator.sv
// Directed bench for baud_tick_generator: default rate, fractional periods, bit ticks,
// enable hold, load/reset collisions, and divisor extremes on a narrow second instance.
module tb_baud_tick_generator;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   tq[$];
    int   bq[$];

    always #5 clk = ~clk;

    baud_tick_generator_if #(.N(16), .F(4)) bus0 ();
    baud_tick_generator_if #(.N(4),  .F(4)) bus1 ();

    baud_tick_generator #(.N(16), .F(4), .OVS(16), .DEF_INT(651), .DEF_FRAC(0)) dut0 (
        .i_clk(clk), .i_reset(rst), .bus(bus0)
    );
    baud_tick_generator #(.N(4), .F(4), .OVS(1), .DEF_INT(5), .DEF_FRAC(0)) dut1 (
        .i_clk(clk), .i_reset(rst), .bus(bus1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    // Runs n cycles from just after a rising edge; tick cycles are numbered from 1.
    task automatic run(input int which, input int n);
        tq.delete();
        bq.delete();
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if ((which == 0 ? bus0.o_tick : bus1.o_tick) === 1'b1) tq.push_back(i);
            if ((which == 0 ? bus0.o_bit_tick : bus1.o_bit_tick) === 1'b1) bq.push_back(i);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input int which, input int vi, input int vf);
        if (which == 0) begin
            bus0.i_div_int  = 16'(vi);
            bus0.i_div_frac = 4'(vf);
            bus0.i_load     = 1'b1;
        end else begin
            bus1.i_div_int  = 4'(vi);
            bus1.i_div_frac = 4'(vf);
            bus1.i_load     = 1'b1;
        end
        @(negedge clk);
        chk("tick_on_load", int'(which == 0 ? bus0.o_tick : bus1.o_tick), 0);
        @(posedge clk);
        #1;
        bus0.i_load = 1'b0;
        bus1.i_load = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus0.i_enable   = 1'b1;
        bus0.i_load     = 1'b0;
        bus0.i_div_int  = '0;
        bus0.i_div_frac = '0;
        bus1.i_enable   = 1'b0;
        bus1.i_load     = 1'b0;
        bus1.i_div_int  = '0;
        bus1.i_div_frac = '0;

        repeat (3) @(negedge clk);
        chk("reset_tick", int'(bus0.o_tick), 0);
        chk("reset_bit_tick", int'(bus0.o_bit_tick), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Defaults: period 651, first bit tick on the 16th tick.
        run(0, 10416);
        chk("def_tick_count", tq.size(), 16);
        chk("def_tick1", qat(tq, 0), 651);
        chk("def_tick2", qat(tq, 1), 1302);
        chk("def_tick3", qat(tq, 2), 1953);
        chk("def_bit_count", bq.size(), 1);
        chk("def_bit1", qat(bq, 0), 10416);

        // 4 + 8/16: periods 4,4,5,4,5,...
        do_load(0, 4, 8);
        run(0, 143);
        chk("frac_tick_count", tq.size(), 32);
        chk("frac_tick2", qat(tq, 1), 8);
        chk("frac_tick3", qat(tq, 2), 13);
        chk("frac_tick4", qat(tq, 3), 17);
        chk("frac_last", qat(tq, 31), 143);

        // 3 + 0: bit tick every 48 cycles.
        do_load(0, 3, 0);
        run(0, 96);
        chk("ovs_tick_count", tq.size(), 32);
        chk("ovs_bit_count", bq.size(), 2);
        chk("ovs_bit1", qat(bq, 0), 48);
        chk("ovs_bit2", qat(bq, 1), 96);

        // Hold: 6 enabled cycles leave cnt=6, so 4 more are needed after re-enable.
        do_load(0, 10, 0);
        run(0, 6);
        chk("hold_pre_ticks", tq.size(), 0);
        bus0.i_enable = 1'b0;
        run(0, 7);
        chk("hold_off_ticks", tq.size(), 0);
        bus0.i_enable = 1'b1;
        run(0, 14);
        chk("hold_resume_count", tq.size(), 2);
        chk("hold_resume1", qat(tq, 0), 4);
        chk("hold_resume2", qat(tq, 1), 14);

        // Load coinciding with term: tick suppressed, full period follows.
        do_load(0, 5, 0);
        run(0, 4);
        chk("coll_pre_ticks", tq.size(), 0);
        do_load(0, 5, 0);
        run(0, 5);
        chk("coll_count", tq.size(), 1);
        chk("coll_tick1", qat(tq, 0), 5);

        // Reset pulse mid-period restores 651/0.
        run(0, 2);
        #1 rst = 1'b1;
        #2;
        chk("rst_pulse_tick", int'(bus0.o_tick), 0);
        rst = 1'b0;
        run(0, 651);
        chk("rst_restart_count", tq.size(), 1);
        chk("rst_restart_tick1", qat(tq, 0), 651);

        // Divisors 0 and 1 both tick every cycle.
        do_load(0, 0, 0);
        run(0, 5);
        chk("div0_count", tq.size(), 5);
        do_load(0, 1, 0);
        run(0, 5);
        chk("div1_count", tq.size(), 5);

        // Narrow instance at 2^N-1 + 15/16: periods 15,15,16 with OVS=1.
        bus0.i_enable = 1'b0;
        bus1.i_enable = 1'b1;
        do_load(1, 15, 15);
        run(1, 46);
        chk("max_count", tq.size(), 3);
        chk("max_tick1", qat(tq, 0), 15);
        chk("max_tick2", qat(tq, 1), 30);
        chk("max_tick3", qat(tq, 2), 46);
        chk("ovs1_bit_count", bq.size(), 3);
        chk("ovs1_bit3", qat(bq, 2), 46);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
